// File: rtl/fifo_synch.sv
// fifo_synch: first-word-fall-through synchronous FIFO, async active-low rst.
// Define FIFO_SYNCH_ASSERT_EN to compile in simulation-only misuse checks.
module fifo_synch #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  isfull,
  output logic                  isempty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;

  logic w_empty;
  logic w_full;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                   (r_wptr[AW] != r_rptr[AW]);

  // A read frees a slot in the same edge, so full+read still accepts a write
  assign w_wr = wr_en && (!w_full || rd_en);
  assign w_rd = rd_en && !w_empty;

  assign isempty = w_empty;
  assign isfull  = w_full;
  assign dout    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

`ifdef FIFO_SYNCH_ASSERT_EN
  always @(posedge clk) begin
    if (rst && wr_en && w_full && !rd_en)
      $error("fifo_synch: write dropped while full");
    if (rst && rd_en && w_empty)
      $error("fifo_synch: read while empty");
  end
`else
`endif

endmodule

// File: tb/tb_fifo_synch.sv
// tb_fifo_synch: scoreboard bench for fifo_synch.
// Inputs driven on negedge, outputs checked before the next posedge.
module tb_fifo_synch;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       isfull;
  logic       isempty;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];

  fifo_synch #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .din(din),
    .dout(dout),
    .isfull(isfull),
    .isempty(isempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("isempty", 32'(isempty), 32'(q.size() == 0));
    chk("isfull", 32'(isfull), 32'(q.size() == 16));
    if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
    else chk("dout_zero", 32'(dout), 32'd0);
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [7:0] d);
    logic acc_w;
    logic acc_r;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    #1;
    chk_state();
    acc_r = r && (q.size() > 0);
    acc_w = w && ((q.size() < 16) || r);
    if (acc_r) void'(q.pop_front());
    if (acc_w) q.push_back(d);
    @(posedge clk);
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(base + i));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++)
      cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_empty", 32'(isempty), 32'd1);
    chk("rst_full", 32'(isfull), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    q.delete();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    #2;
    chk("por_empty", 32'(isempty), 32'd1);
    chk("por_full", 32'(isfull), 32'd0);
    chk("por_dout", 32'(dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);

    fill(1);
    drain();

    for (int i = 0; i < 10; i++)
      cyc(i % 2 == 0, i % 3 == 0, 8'(8'h30 + i));
    drain();

    fill(1);
    cyc(1'b1, 1'b0, 8'hEE);
    drain();

    cyc(1'b1, 1'b1, 8'hA5);
    cyc(1'b0, 1'b0, 8'h00);
    chk("uflow_dout", 32'(dout), 32'hA5);
    drain();

    fill(8'h41);
    cyc(1'b1, 1'b1, 8'h77);
    cyc(1'b0, 1'b0, 8'h00);
    chk("fb_full", 32'(isfull), 32'd1);
    chk("fb_dout", 32'(dout), 32'h42);
    drain();

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    reset_mid();
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b0, 1'b0, 8'h00);
    chk("post_rst", 32'(dout), 32'h99);
    drain();

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
